// File: rtl/bsg_fsb_node_ls_sequencer_pkg.sv
// Shared types for the FSB node level-shift power sequencer.
// Holds the state encoding, command encodings and the per-state output decode.
package bsg_fsb_node_ls_sequencer_pkg;

  localparam int unsigned StateWidth = 3;

  typedef enum logic [StateWidth-1:0] {
    StOff     = 3'd0,
    StPwrUp   = 3'd1,
    StReset   = 3'd2,
    StOn      = 3'd3,
    StDrain   = 3'd4,
    StIsolate = 3'd5,
    StPwrDown = 3'd6
  } state_e;

  // Command encodings carried on cmd_on_i
  localparam logic e_cmd_off = 1'b0;
  localparam logic e_cmd_on  = 1'b1;

  typedef struct packed {
    logic pwr_en;
    logic en_ls;
    logic node_reset;
    logic fsb_block;
    logic on;
    logic cmd_ready;
  } seq_out_t;

  // Moore output decode; the safe (fully isolated, powered off) vector is the default
  function automatic seq_out_t state_outputs(input state_e st);
    seq_out_t o;
    o = '{pwr_en: 1'b0, en_ls: 1'b0, node_reset: 1'b1, fsb_block: 1'b1, on: 1'b0,
          cmd_ready: 1'b0};
    unique case (st)
      StOff: begin
        o.cmd_ready = 1'b1;
      end
      StPwrUp: begin
        o.pwr_en = 1'b1;
      end
      StReset: begin
        o.pwr_en = 1'b1;
        o.en_ls  = 1'b1;
      end
      StOn: begin
        o.pwr_en     = 1'b1;
        o.en_ls      = 1'b1;
        o.node_reset = 1'b0;
        o.fsb_block  = 1'b0;
        o.on         = 1'b1;
        o.cmd_ready  = 1'b1;
      end
      StDrain: begin
        o.pwr_en     = 1'b1;
        o.en_ls      = 1'b1;
        o.node_reset = 1'b0;
      end
      StIsolate: begin
        // Isolate first while the supply is still requested
        o.pwr_en = 1'b1;
      end
      StPwrDown: begin
      end
      default: begin
      end
    endcase
    return o;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bsg_fsb_node_ls_seq_ctr.sv
// Loadable saturating up-counter with synchronous clear and terminal-count compare.
// Shared by the reset-hold, drain-quiet and power-timeout phases of the sequencer.
module bsg_fsb_node_ls_seq_ctr #(
  parameter int unsigned width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clr_i,
  input  logic               ld_i,
  input  logic [width_p-1:0] ld_val_i,
  input  logic               en_i,
  input  logic [width_p-1:0] term_i,
  output logic               tc_o
);

  logic [width_p-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats increment; holds once the terminal count is reached
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (en_i && (cnt_q != term_i)) begin
      cnt_d = cnt_q + width_p'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/bsg_fsb_node_ls_sequencer.sv
// Power/isolation sequencer for one FSB node domain.
// Orders supply enable, level-shifter enable and node reset on power-up and power-down,
// draining FSB traffic before isolation.
// Optional power-good timeout: define BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN.
module bsg_fsb_node_ls_sequencer
  import bsg_fsb_node_ls_sequencer_pkg::*;
#(
  parameter int unsigned reset_cycles_p = 16,
  parameter int unsigned quiet_cycles_p = 8,
  parameter int unsigned pwr_timeout_p  = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic cmd_v_i,
  input  logic cmd_on_i,
  output logic cmd_ready_o,
  input  logic pwr_good_i,
  input  logic fsb_v_o_i,
  input  logic node_v_o_i,
  output logic pwr_en_o,
  output logic en_ls_o,
  output logic node_reset_o,
  output logic fsb_block_o,
  output logic on_o,
  output logic error_o
);

  localparam int unsigned CtrWidth =
      $clog2(max3(reset_cycles_p, quiet_cycles_p, pwr_timeout_p) + 1);

  // Terminal counts are N-1: the counter starts at 0 on the first cycle of a phase
  localparam logic [CtrWidth-1:0] ResetTerm = CtrWidth'(reset_cycles_p - 1);
  localparam logic [CtrWidth-1:0] QuietTerm = CtrWidth'(quiet_cycles_p - 1);
`ifdef BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN
  localparam logic [CtrWidth-1:0] TimeoutTerm = CtrWidth'(pwr_timeout_p - 1);
`endif

  state_e   state_q, state_d;
  seq_out_t out_q;

  logic                cmd_acc;
  logic                busy;
  logic                ctr_clr, ctr_ld, ctr_en, ctr_tc;
  logic [CtrWidth-1:0] ctr_term;

`ifdef BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN
  logic timeout_hit;
  logic error_q, error_d;
`endif

  assign cmd_acc = cmd_v_i & out_q.cmd_ready;
  assign busy    = fsb_v_o_i | node_v_o_i;

  // Next-state and counter control
  always_comb begin
    state_d  = state_q;
    ctr_ld   = 1'b0;
    ctr_en   = 1'b0;
    ctr_term = '0;
`ifdef BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    unique case (state_q)
      StOff: begin
        if (cmd_acc && (cmd_on_i == e_cmd_on)) state_d = StPwrUp;
      end
      StPwrUp: begin
`ifdef BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN
        ctr_term = TimeoutTerm;
`endif
        if (pwr_good_i) begin
          state_d = StReset;
        end
`ifdef BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN
        else if (ctr_tc) begin
          state_d     = StOff;
          timeout_hit = 1'b1;
        end else begin
          ctr_en = 1'b1;
        end
`endif
      end
      StReset: begin
        ctr_term = ResetTerm;
        if (ctr_tc) state_d = StOn;
        else        ctr_en  = 1'b1;
      end
      StOn: begin
        if (cmd_acc && (cmd_on_i == e_cmd_off)) state_d = StDrain;
      end
      StDrain: begin
        ctr_term = QuietTerm;
        // Any traffic restarts the quiet window, even on the would-be final cycle
        if (busy)        ctr_ld  = 1'b1;
        else if (ctr_tc) state_d = StIsolate;
        else             ctr_en  = 1'b1;
      end
      StIsolate: begin
        state_d = StPwrDown;
      end
      StPwrDown: begin
`ifdef BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN
        ctr_term = TimeoutTerm;
`endif
        if (!pwr_good_i) begin
          state_d = StOff;
        end
`ifdef BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN
        else if (ctr_tc) begin
          state_d     = StOff;
          timeout_hit = 1'b1;
        end else begin
          ctr_en = 1'b1;
        end
`endif
      end
      default: begin
        state_d = StOff;
      end
    endcase
  end

  // Every phase starts its count from zero
  assign ctr_clr = (state_d != state_q);

  bsg_fsb_node_ls_seq_ctr #(
    .width_p (CtrWidth)
  ) u_ctr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (ctr_clr),
    .ld_i     (ctr_ld),
    .ld_val_i ('0),
    .en_i     (ctr_en),
    .term_i   (ctr_term),
    .tc_o     (ctr_tc)
  );

  // State register with outputs registered from the next state, so they are glitch-free
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StOff;
      out_q   <= state_outputs(StOff);
    end else begin
      state_q <= state_d;
      out_q   <= state_outputs(state_d);
    end
  end

`ifdef BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN
  // Sticky error: set on timeout, cleared by the next accepted command
  always_comb begin
    error_d = error_q;
    if (cmd_acc)     error_d = 1'b0;
    if (timeout_hit) error_d = 1'b1;
  end

  // Error register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

  assign cmd_ready_o  = out_q.cmd_ready;
  assign pwr_en_o     = out_q.pwr_en;
  assign en_ls_o      = out_q.en_ls;
  assign node_reset_o = out_q.node_reset;
  assign fsb_block_o  = out_q.fsb_block;
  assign on_o         = out_q.on;

endmodule

// File: tb/tb_bsg_fsb_node_ls_sequencer.sv
// Self-checking bench for bsg_fsb_node_ls_sequencer with a phase-level reference model.
module tb_bsg_fsb_node_ls_sequencer;

  localparam int R = 16;
  localparam int Q = 8;
  localparam int T = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_r, cmd_v, cmd_on, pwr_good, fsb_v, node_v;
  logic cmd_ready, pwr_en, en_ls, node_reset, fsb_block, on, error;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: 0 off, 1 powering up, 2 node reset, 3 on, 4 draining, 5 isolate, 6 powering down
  int m_phase = 0;
  int m_cnt   = 0;
  bit m_err   = 1'b0;

  bsg_fsb_node_ls_sequencer #(
    .reset_cycles_p (R),
    .quiet_cycles_p (Q),
    .pwr_timeout_p  (T)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_r),
    .cmd_v_i      (cmd_v),
    .cmd_on_i     (cmd_on),
    .cmd_ready_o  (cmd_ready),
    .pwr_good_i   (pwr_good),
    .fsb_v_o_i    (fsb_v),
    .node_v_o_i   (node_v),
    .pwr_en_o     (pwr_en),
    .en_ls_o      (en_ls),
    .node_reset_o (node_reset),
    .fsb_block_o  (fsb_block),
    .on_o         (on),
    .error_o      (error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected {pwr_en, en_ls, node_reset, fsb_block, on, cmd_ready, error}
  function automatic logic [6:0] exp_vec();
    logic [5:0] v;
    case (m_phase)
      0:       v = 6'b001101;
      1:       v = 6'b101100;
      2:       v = 6'b111100;
      3:       v = 6'b110011;
      4:       v = 6'b110100;
      5:       v = 6'b101100;
      default: v = 6'b001100;
    endcase
    return {v, m_err};
  endfunction

  task automatic wait_step();
`ifdef BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN
    m_cnt++;
    if (m_cnt == T) begin
      m_phase = 0;
      m_err   = 1'b1;
    end
`endif
  endtask

  // Advance the model by one clock using the inputs the DUT will sample
  task automatic model_step();
    if (reset_r) begin
      m_phase = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
    end else begin
      case (m_phase)
        0: if (cmd_v) begin
          m_err = 1'b0;
          if (cmd_on) begin
            m_phase = 1;
            m_cnt   = 0;
          end
        end
        1: if (pwr_good) begin
          m_phase = 2;
          m_cnt   = 0;
        end else wait_step();
        2: begin
          m_cnt++;
          if (m_cnt == R) m_phase = 3;
        end
        3: if (cmd_v && !cmd_on) begin
          m_phase = 4;
          m_cnt   = 0;
        end
        4: begin
          if (fsb_v || node_v) m_cnt = 0;
          else                 m_cnt++;
          if (m_cnt == Q) m_phase = 5;
        end
        5: begin
          m_phase = 6;
          m_cnt   = 0;
        end
        default: if (!pwr_good) m_phase = 0;
                 else           wait_step();
      endcase
    end
  endtask

  // One clock: model update, edge, then compare on the falling edge
  task automatic tick();
    logic ok;
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    chk("outputs", {25'd0, pwr_en, en_ls, node_reset, fsb_block, on, cmd_ready, error},
        {25'd0, exp_vec()});
    ok = !(en_ls && !pwr_en) && (en_ls || node_reset);
    chk("ordering", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    reset_r = 1'b1; cmd_v = 1'b0; cmd_on = 1'b0;
    pwr_good = 1'b0; fsb_v = 1'b0; node_v = 1'b0;
    tick();
    tick();
    chk("rst_ready",      cmd_ready,  1);
    chk("rst_pwr_en",     pwr_en,     0);
    chk("rst_en_ls",      en_ls,      0);
    chk("rst_node_reset", node_reset, 1);
    chk("rst_fsb_block",  fsb_block,  1);
    chk("rst_on",         on,         0);
    chk("rst_error",      error,      0);
    reset_r = 1'b0;
    tick();

    // Redundant off command while off
    cmd_v = 1'b1; cmd_on = 1'b0;
    tick();
    cmd_v = 1'b0;
    chk("off_noop_pwr_en", pwr_en,    0);
    chk("off_noop_ready",  cmd_ready, 1);
    tick();

    // Power-up; command held valid throughout (held off, then a no-op once on)
    cmd_v = 1'b1; cmd_on = 1'b1;
    tick();                                       // t+1
    chk("pu_pwr_en_t1", pwr_en,    1);
    chk("pu_ready_t1",  cmd_ready, 0);
    repeat (4) tick();                            // t+5
    chk("pu_en_ls_t5", en_ls,     0);
    chk("pu_ready_t5", cmd_ready, 0);
    pwr_good = 1'b1;
    tick();                                       // t+6
    chk("pu_en_ls_t6", en_ls,      1);
    chk("pu_reset_t6", node_reset, 1);
    repeat (15) tick();                           // t+21
    chk("pu_reset_t21", node_reset, 1);
    tick();                                       // t+22
    chk("pu_reset_t22", node_reset, 0);
    chk("pu_on_t22",    on,         1);
    tick();
    cmd_v = 1'b0;
    chk("on_noop_on", on, 1);

    // Drain with traffic pulses
    cmd_v = 1'b1; cmd_on = 1'b0; fsb_v = 1'b1;
    tick();
    cmd_v = 1'b0;
    chk("dr_block", fsb_block, 1);
    chk("dr_on",    on,        0);
    fsb_v = 1'b0; tick();
    fsb_v = 1'b1; tick();
    fsb_v = 1'b0; tick();
    fsb_v = 1'b1; tick();                         // last fsb pulse
    fsb_v = 1'b0;
    repeat (Q - 1) tick();
    node_v = 1'b1;                                // lands on the would-be final cycle
    tick();
    node_v = 1'b0;
    chk("dr_restart_en_ls", en_ls, 1);
    repeat (Q - 1) tick();
    chk("dr_en_ls_held", en_ls, 1);
    tick();
    chk("dr_en_ls_fall",  en_ls,  0);
    chk("dr_pwr_en_held", pwr_en, 1);
    tick();
    chk("dr_pwr_en_fall", pwr_en,    0);
    chk("dr_ready_busy",  cmd_ready, 0);
    pwr_good = 1'b0;
    tick();
    chk("dr_off_ready", cmd_ready, 1);

    // Reset in the middle of the node-reset phase
    cmd_v = 1'b1; cmd_on = 1'b1;
    tick();
    cmd_v = 1'b0; pwr_good = 1'b1;
    tick();
    repeat (3) tick();
    chk("mr_in_reset_en_ls", en_ls, 1);
    reset_r = 1'b1;
    tick();
    chk("mr_en_ls",      en_ls,      0);
    chk("mr_pwr_en",     pwr_en,     0);
    chk("mr_node_reset", node_reset, 1);
    chk("mr_ready",      cmd_ready,  1);
    reset_r = 1'b0; pwr_good = 1'b0;
    tick();

`ifdef BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN
    // Power-good never arrives
    cmd_v = 1'b1; cmd_on = 1'b1;
    tick();                                       // t+1
    cmd_v = 1'b0;
    repeat (T - 1) tick();                        // t+255
    chk("to_err_pre", error,  0);
    chk("to_pwr_pre", pwr_en, 1);
    tick();                                       // t+256
    chk("to_err",    error,     1);
    chk("to_pwr_en", pwr_en,    0);
    chk("to_ready",  cmd_ready, 1);
    cmd_v = 1'b1; cmd_on = 1'b0;
    tick();
    cmd_v = 1'b0;
    chk("to_err_clr", error, 0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bsg_fsb_node_ls_sequencer.md
# bsg_fsb_node_ls_sequencer

Power/isolation sequencer for one FSB node domain. It drives the level-shifter enable (`en_ls`), the node power-enable request and the node reset, and powers the node domain up and down in a safe order. Before isolating, it blocks new FSB-to-node traffic and waits for both directions to go quiet. It sits in the always-on FSB domain next to the node level-shift wrapper, and its `en_ls_o` feeds that wrapper's `en_ls_i`.

## Interface
Parameters:
- `reset_cycles_p`, 16: cycles node reset is held after isolation release; ≥1.
- `quiet_cycles_p`, 8: consecutive idle cycles required to finish a drain; ≥1.
- `pwr_timeout_p`, 255: maximum wait for a power-good edge. Used only with the timeout feature.

Ports:
- `clk_i`  in  1  FSB-domain clock.
- `reset_i`  in  1  Synchronous, active-high reset.
- `cmd_v_i`  in  1  Command valid.
- `cmd_on_i`  in  1  1 = power node up, 0 = power node down.
- `cmd_ready_o`  out  1  Command accepted when `cmd_v_i & cmd_ready_o`.
- `pwr_good_i`  in  1  Node supply good. Already synchronous to `clk_i`.
- `fsb_v_o_i`  in  1  FSB→node valid; monitored during drain.
- `node_v_o_i`  in  1  Node→FSB valid; monitored during drain.
- `pwr_en_o`  out  1  Request node supply on.
- `en_ls_o`  out  1  Level-shifter enable; 0 = isolated.
- `node_reset_o`  out  1  Reset to the node domain.
- `fsb_block_o`  out  1  Tells the FSB to stop issuing to the node.
- `on_o`  out  1  Node is fully up.
- `error_o`  out  1  Sticky power-timeout error.

## Operation
States: OFF, PWR_UP, RESET, ON, DRAIN, ISOLATE, PWR_DOWN. Outputs are Moore-decoded from the state register.
- **OFF:** `pwr_en`=0, `en_ls`=0, `node_reset`=1, `fsb_block`=1. `cmd_ready`=1.
  - Accepted `cmd_on`=1 → PWR_UP.
  - Accepted `cmd_on`=0 is a no-op; state stays OFF.
- **PWR_UP:** `pwr_en`=1, still isolated. `pwr_good_i`=1 → RESET.
- **RESET:** `pwr_en`=1, `en_ls`=1, `node_reset`=1. Held exactly `reset_cycles_p` cycles, then → ON.
- **ON:** `node_reset`=0, `fsb_block`=0, `on_o`=1, `cmd_ready`=1.
  - `cmd_on`=0 → DRAIN.
  - `cmd_on`=1 is a no-op.
- **DRAIN:** as ON but `fsb_block`=1 and `on_o`=0. The quiet counter:
  - reloads on any cycle with `fsb_v_o_i | node_v_o_i`;
  - otherwise counts;
  - after `quiet_cycles_p` consecutive idle cycles → ISOLATE.
- **ISOLATE:** `en_ls`=0, `node_reset`=1, `pwr_en`=1. Lasts one cycle → PWR_DOWN.
- **PWR_DOWN:** `pwr_en`=0, isolated. `pwr_good_i`=0 → OFF.
- `cmd_ready_o` is 0 in every transitional state. Commands presented then are held off, not dropped.
- Counter width is $clog2(max(reset_cycles_p, quiet_cycles_p, pwr_timeout_p)+1). It never wraps; it saturates at its terminal count.

## Timing
- Reset values: state OFF, `pwr_en_o`=0, `en_ls_o`=0, `node_reset_o`=1, `fsb_block_o`=1, `on_o`=0, `error_o`=0, `cmd_ready_o`=1.
- A command accepted at cycle t changes the outputs at t+1.
- `pwr_good_i` sampled high at t' → `en_ls_o`=1 at t'+1. `node_reset_o` falls at t'+1+`reset_cycles_p`.
- Ordering guarantees, without exception:
  - `en_ls_o` never rises while `pwr_en_o`=0.
  - `pwr_en_o` never falls while `en_ls_o`=1.
  - `node_reset_o`=1 whenever `en_ls_o`=0.
- Drain with no traffic: ON→ISOLATE takes 1+`quiet_cycles_p` cycles after acceptance.
- A valid in the same cycle the counter would terminate restarts the count.
- `reset_i` mid-sequence forces OFF next cycle and drops all outputs to reset values. An abrupt isolation is accepted here.

## Configuration
Macro: `BSG_FSB_NODE_LS_SEQUENCER_TIMEOUT_EN`.
- **Defined:** in PWR_UP/PWR_DOWN the counter counts cycles waiting for `pwr_good_i`. On reaching `pwr_timeout_p`:
  - `error_o` sets;
  - state goes to OFF (`pwr_en`=0, isolated);
  - `error_o` clears on the next accepted command or on reset.
- **Undefined:** waits indefinitely; `error_o` is tied to 0; the timeout counter logic is absent.

## Structure
- Package `bsg_fsb_node_ls_sequencer_pkg` holds:
  - the state enum and its width;
  - the command encodings `e_cmd_off` = 0 and `e_cmd_on` = 1.
- One sub-module, `bsg_fsb_node_ls_seq_ctr`: a loadable saturating up-counter with clear and terminal-count compare. It is shared by the RESET, DRAIN and timeout phases, since only one is active at a time.

## Test plan
- **Reset:** hold `reset_i` 2 cycles → all outputs at reset values, `cmd_ready_o`=1.
- **Power-up:** `cmd_on`=1 at t, `pwr_good_i` rises at t+5 →
  - `pwr_en_o`=1 at t+1;
  - `en_ls_o`=1 at t+6;
  - `node_reset_o`=0 and `on_o`=1 at t+22 (`reset_cycles_p`=16).
- **Drain with traffic:** from ON, `cmd_on`=0 with `fsb_v_o_i` pulsing for 3 more cycles →
  - `fsb_block_o`=1 next cycle;
  - `en_ls_o` falls 8 idle cycles after the last pulse, plus 1;
  - `pwr_en_o` falls one cycle later;
  - OFF after `pwr_good_i` drops.
- **Redundant/busy commands:** `cmd_on`=0 in OFF → accepted, no output change. Any command during PWR_UP → `cmd_ready_o`=0 and the command is held.
- **Timeout (macro defined):** `pwr_good_i` stuck 0 after `cmd_on`=1 → `error_o`=1 and OFF after 255 cycles; next accepted command clears `error_o`.
- **Mid-sequence reset:** `reset_i` during RESET → next cycle OFF, `en_ls_o`=0, `pwr_en_o`=0.
